// File: rtl/spi_burst_slave.sv
// spi_burst_slave
//   SPI slave (1/2/4 data lanes) that decodes a header of address then
//   command, and then moves one word (or a burst of words) of write or read
//   data. All logic runs on clk. sclk and cs_n are synchronized and
//   edge-detected internally.
//
// Ports
//   clk, reset_n       system clock, asynchronous active-low reset
//   sclk, cs_n         SPI clock and chip select (asynchronous to clk)
//   mosi[3:0]          master data lanes, lane 0 = lowest bit
//   spi_mode[1:0]      01 = 1 lane, 10 = 2 lanes, 11 = 4 lanes, 00 = frame ignored
//   miso[3:0], miso_oe slave data lanes and their drive enable
//   addr, cmd          transfer address and latched command (bit2 write, bit1 burst)
//   hdr_valid          one-clk pulse when the header has been received
//   wr_valid, wdata    one-clk pulse with the received write word
//   rd_req             one-clk read request for addr
//   rd_ack, rdata      read data strobe and word
//   busy               frame in progress
//   err_rd_late        sticky: read data was not available in time
module spi_burst_slave #(
  parameter int ADDR_W   = 20,
  parameter int CMD_W    = 4,
  parameter int DATA_W   = 16,
  parameter int TURN_CYC = 4
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              sclk,
  input  logic              cs_n,
  input  logic [3:0]        mosi,
  input  logic [1:0]        spi_mode,
  output logic [3:0]        miso,
  output logic              miso_oe,
  output logic [ADDR_W-1:0] addr,
  output logic [CMD_W-1:0]  cmd,
  output logic              hdr_valid,
  output logic              wr_valid,
  output logic [DATA_W-1:0] wdata,
  output logic              rd_req,
  input  logic              rd_ack,
  input  logic [DATA_W-1:0] rdata,
  output logic              busy,
  output logic              err_rd_late
);

  localparam int HDR_BITS = ADDR_W + CMD_W;
  localparam int MAX_BITS = (HDR_BITS > DATA_W) ? HDR_BITS : DATA_W;
  localparam int CNT_W    = $clog2(MAX_BITS + 1);
  localparam int TURN_W   = (TURN_CYC > 1) ? $clog2(TURN_CYC) : 1;

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_HDR   = 3'd1;
  localparam logic [2:0] S_TURN  = 3'd2;
  localparam logic [2:0] S_DATA  = 3'd3;
  localparam logic [2:0] S_ABORT = 3'd4;  // disabled-mode frame, wait for cs_n high

  // ---------------------------------------------------------------------------
  // Synchronizers and edge strobes. The strobes are registered so they appear
  // 3 clk after the pad transition.
  // ---------------------------------------------------------------------------
  logic sclk_s1, sclk_s2, sclk_s3;
  logic cs_s1, cs_s2, cs_s3;
  logic sclk_rise, sclk_fall;
  logic cs_fall, cs_high;

  // NOTE: sequential state is assigned with <= so every flop samples the
  // pre-edge value of its neighbours; blocking here would collapse the chain.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sclk_s1   <= 1'b0;
      sclk_s2   <= 1'b0;
      sclk_s3   <= 1'b0;
      sclk_rise <= 1'b0;
      sclk_fall <= 1'b0;
      cs_s1     <= 1'b0;
      cs_s2     <= 1'b0;
      cs_s3     <= 1'b0;
    end else begin
      sclk_s1   <= sclk;
      sclk_s2   <= sclk_s1;
      sclk_s3   <= sclk_s2;
      sclk_rise <= sclk_s2 & ~sclk_s3;
      sclk_fall <= ~sclk_s2 & sclk_s3;
      cs_s1     <= cs_n;
      cs_s2     <= cs_s1;
      cs_s3     <= cs_s2;
    end
  end

  // The synchronizer resets to 0, so a reset released while cs_n is already
  // low never produces a falling edge: the block waits for a fresh frame.
  assign cs_fall = cs_s3 & ~cs_s2;
  assign cs_high = cs_s2;

  // ---------------------------------------------------------------------------
  // Frame state
  // ---------------------------------------------------------------------------
  logic [2:0]          state;
  logic [2:0]          lanes;     // 1, 2 or 4 for the current frame
  logic [CNT_W-1:0]    bit_cnt;
  logic [TURN_W-1:0]   turn_cnt;
  logic [HDR_BITS-1:0] hdr_sr;
  logic [DATA_W-1:0]   wsr;
  logic [DATA_W-1:0]   tx_sr;
  logic [DATA_W-1:0]   rdata_q;
  logic                rd_wait;   // request outstanding, rd_ack accepted
  logic                rd_have;   // rdata_q holds the word for this slot

  logic [CNT_W-1:0]    step;
  logic [CNT_W-1:0]    cnt_next;
  logic                hdr_last;
  logic                data_last;
  logic                turn_last;
  logic [HDR_BITS-1:0] hdr_next;
  logic [DATA_W-1:0]   data_next;

  // NOTE: every always_comb output gets a default first so no path leaves a
  // value unassigned, which would otherwise infer a latch.
  always_comb begin
    step      = CNT_W'(lanes);
    cnt_next  = bit_cnt + step;
    hdr_last  = (cnt_next == CNT_W'(HDR_BITS));
    data_last = (cnt_next == CNT_W'(DATA_W));
    turn_last = (turn_cnt == TURN_W'(TURN_CYC - 1));
    hdr_next  = hdr_sr;
    data_next = wsr;
    // LSB first: new bits enter at the top and move down as the word fills.
    case (lanes)
      3'd4: begin
        hdr_next  = {mosi, hdr_sr[HDR_BITS-1:4]};
        data_next = {mosi, wsr[DATA_W-1:4]};
      end
      3'd2: begin
        hdr_next  = {mosi[1:0], hdr_sr[HDR_BITS-1:2]};
        data_next = {mosi[1:0], wsr[DATA_W-1:2]};
      end
      default: begin
        hdr_next  = {mosi[0], hdr_sr[HDR_BITS-1:1]};
        data_next = {mosi[0], wsr[DATA_W-1:1]};
      end
    endcase
  end

  // Low lanes of a word, unused lanes forced to 0.
  function automatic logic [3:0] lane_out(input logic [DATA_W-1:0] w,
                                          input logic [2:0] l);
    case (l)
      3'd4:    lane_out = w[3:0];
      3'd2:    lane_out = {2'b00, w[1:0]};
      default: lane_out = {3'b000, w[0]};
    endcase
  endfunction

  // NOTE: the shift registers and captured read word are reset along with the
  // control state, so nothing observable depends on power-up contents.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state       <= S_IDLE;
      lanes       <= 3'd0;
      bit_cnt     <= '0;
      turn_cnt    <= '0;
      hdr_sr      <= '0;
      wsr         <= '0;
      tx_sr       <= '0;
      rdata_q     <= '0;
      rd_wait     <= 1'b0;
      rd_have     <= 1'b0;
      addr        <= '0;
      cmd         <= '0;
      wdata       <= '0;
      miso        <= '0;
      hdr_valid   <= 1'b0;
      wr_valid    <= 1'b0;
      rd_req      <= 1'b0;
      err_rd_late <= 1'b0;
    end else begin
      hdr_valid <= 1'b0;
      wr_valid  <= 1'b0;
      rd_req    <= 1'b0;

      if (rd_ack && rd_wait) begin
        rdata_q <= rdata;
        rd_have <= 1'b1;
        rd_wait <= 1'b0;
      end

      // Burst writes advance the address once the completed word has been
      // presented with its own address.
      if (wr_valid && cmd[1]) addr <= addr + ADDR_W'(1);

      if (state != S_DATA || cmd[2]) miso <= '0;

      case (state)
        S_IDLE: begin
          if (cs_fall) begin
            bit_cnt  <= '0;
            turn_cnt <= '0;
            rd_wait  <= 1'b0;
            rd_have  <= 1'b0;
            if (spi_mode == 2'b00) begin
              state <= S_ABORT;
            end else begin
              case (spi_mode)
                2'b01:   lanes <= 3'd1;
                2'b10:   lanes <= 3'd2;
                default: lanes <= 3'd4;
              endcase
              err_rd_late <= 1'b0;
              state       <= S_HDR;
            end
          end
        end

        S_HDR: begin
          if (sclk_rise) begin
            hdr_sr <= hdr_next;
            if (hdr_last) begin
              addr      <= hdr_next[ADDR_W-1:0];
              cmd       <= hdr_next[HDR_BITS-1:ADDR_W];
              hdr_valid <= 1'b1;
              bit_cnt   <= '0;
              if (hdr_next[ADDR_W+2]) begin
                state <= S_DATA;
              end else begin
                state   <= S_TURN;
                rd_req  <= 1'b1;
                rd_wait <= 1'b1;
                rd_have <= 1'b0;
              end
            end else begin
              bit_cnt <= cnt_next;
            end
          end
        end

        S_TURN: begin
          if (sclk_rise) begin
            if (turn_last) begin
              turn_cnt <= '0;
              bit_cnt  <= '0;
              state    <= S_DATA;
            end else begin
              turn_cnt <= turn_cnt + TURN_W'(1);
            end
          end
        end

        S_DATA: begin
          if (cmd[2]) begin
            if (sclk_rise) begin
              wsr <= data_next;
              if (data_last) begin
                wdata    <= data_next;
                wr_valid <= 1'b1;
                bit_cnt  <= '0;
                if (!cmd[1]) state <= S_IDLE;
              end else begin
                bit_cnt <= cnt_next;
              end
            end
          end else begin
            // The bit counter advances on rising strobes (master samples), so
            // a zero count on a falling strobe marks the first shift of a word.
            if (sclk_fall) begin
              if (bit_cnt == '0) begin
                if (rd_have) begin
                  miso  <= lane_out(rdata_q, lanes);
                  tx_sr <= rdata_q >> lanes;
                end else begin
                  // Too late: send zeros and drop any ack still to come.
                  miso        <= '0;
                  tx_sr       <= '0;
                  err_rd_late <= 1'b1;
                  rd_wait     <= 1'b0;
                end
              end else begin
                miso  <= lane_out(tx_sr, lanes);
                tx_sr <= tx_sr >> lanes;
              end
            end
            if (sclk_rise) begin
              if (data_last) begin
                bit_cnt <= '0;
                if (cmd[1] && !cs_high) begin
                  state   <= S_TURN;
                  addr    <= addr + ADDR_W'(1);
                  rd_req  <= 1'b1;
                  rd_wait <= 1'b1;
                  rd_have <= 1'b0;
                end else begin
                  state <= S_IDLE;
                end
              end else begin
                bit_cnt <= cnt_next;
              end
            end
          end
        end

        S_ABORT: ;

        default: state <= S_IDLE;
      endcase

      // Chip select release ends any frame. A word finishing in this same clk
      // has already been completed above.
      if (cs_high && state != S_IDLE) state <= S_IDLE;
    end
  end

  assign busy    = (state != S_IDLE);
  assign miso_oe = (state == S_DATA) && !cmd[2];

endmodule

// File: tb/tb_spi_burst_slave.sv
// tb_spi_burst_slave
//   Directed bench for spi_burst_slave with default parameters: quad write,
//   single-lane burst read with address wrap, dual-lane late read, aborted
//   write, disabled-mode frame and reset during a header.
module tb_spi_burst_slave;

  localparam int HALF = 8;  // clk cycles per sclk half period

  logic        clk = 1'b0;
  logic        reset_n;
  logic        sclk;
  logic        cs_n;
  logic [3:0]  mosi;
  logic [1:0]  spi_mode;
  logic [3:0]  miso;
  logic        miso_oe;
  logic [19:0] addr;
  logic [3:0]  cmd;
  logic        hdr_valid;
  logic        wr_valid;
  logic [15:0] wdata;
  logic        rd_req;
  logic        rd_ack;
  logic [15:0] rdata;
  logic        busy;
  logic        err_rd_late;

  int vectors     = 0;
  int miscompares = 0;

  int          hdr_cnt = 0;
  int          wr_cnt  = 0;
  int          rd_cnt  = 0;
  logic [19:0] hdr_addr;
  logic [3:0]  hdr_cmd;
  logic [19:0] wr_addr;
  logic [15:0] wr_data;
  logic [19:0] rd_addr [0:7];

  logic        ack_en;
  logic [15:0] ack_data [0:3];
  int          ack_idx;

  spi_burst_slave dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .sclk        (sclk),
    .cs_n        (cs_n),
    .mosi        (mosi),
    .spi_mode    (spi_mode),
    .miso        (miso),
    .miso_oe     (miso_oe),
    .addr        (addr),
    .cmd         (cmd),
    .hdr_valid   (hdr_valid),
    .wr_valid    (wr_valid),
    .wdata       (wdata),
    .rd_req      (rd_req),
    .rd_ack      (rd_ack),
    .rdata       (rdata),
    .busy        (busy),
    .err_rd_late (err_rd_late)
  );

  always #5 clk = ~clk;

  // Pulse recorder, sampled away from the active edge.
  always @(negedge clk) begin
    if (hdr_valid) begin
      hdr_cnt++;
      hdr_addr = addr;
      hdr_cmd  = cmd;
    end
    if (wr_valid) begin
      wr_cnt++;
      wr_addr = addr;
      wr_data = wdata;
    end
    if (rd_req) begin
      if (rd_cnt < 8) rd_addr[rd_cnt] = addr;
      rd_cnt++;
    end
  end

  // Read responder: acks each request 5 clk later with the next table entry.
  initial begin
    rd_ack  = 1'b0;
    rdata   = '0;
    ack_idx = 0;
    forever begin
      @(negedge clk);
      rd_ack = 1'b0;
      if (rd_req && ack_en) begin
        repeat (4) @(negedge clk);
        rdata  = ack_data[ack_idx % 4];
        ack_idx++;
        rd_ack = 1'b1;
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [3:0] lane_mask(input int l);
    if (l == 4) return 4'hF;
    if (l == 2) return 4'h3;
    return 4'h1;
  endfunction

  // One sclk period: drive mosi, hold low, sample miso, raise, hold high, drop.
  task automatic sclk_beat(input logic [3:0] d, output logic [3:0] q, output logic oe);
    mosi = d;
    repeat (HALF) @(negedge clk);
    q    = miso;
    oe   = miso_oe;
    sclk = 1'b1;
    repeat (HALF) @(negedge clk);
    sclk = 1'b0;
  endtask

  task automatic send_bits(input logic [31:0] v, input int nbits, input int l);
    logic [3:0]  q;
    logic        oe;
    logic [31:0] t;
    t = v;
    for (int i = 0; i < nbits / l; i++) begin
      sclk_beat(t[3:0] & lane_mask(l), q, oe);
      t = t >> l;
    end
  endtask

  task automatic recv_bits(input int nbits, input int l, output logic [31:0] w,
                           output logic oe_all, output logic hi_zero);
    logic [3:0] q;
    logic       oe;
    logic [3:0] m;
    m       = lane_mask(l);
    w       = '0;
    oe_all  = 1'b1;
    hi_zero = 1'b1;
    for (int i = 0; i < nbits / l; i++) begin
      sclk_beat(4'h0, q, oe);
      w      = w | (32'(q & m) << (i * l));
      oe_all = oe_all & oe;
      if ((q & ~m) != 4'h0) hi_zero = 1'b0;
    end
  endtask

  task automatic frame_begin(input logic [1:0] mode);
    spi_mode = mode;
    @(negedge clk);
    cs_n = 1'b0;
    repeat (HALF) @(negedge clk);
  endtask

  task automatic frame_end();
    repeat (4) @(negedge clk);
    cs_n = 1'b1;
    repeat (HALF) @(negedge clk);
  endtask

  int          h0, w0, r0;
  logic [31:0] word0, word1;
  logic        oe0, oe1, hz0, hz1;

  initial begin
    reset_n  = 1'b0;
    sclk     = 1'b0;
    cs_n     = 1'b1;
    mosi     = 4'h0;
    spi_mode = 2'b00;
    ack_en   = 1'b0;
    ack_data[0] = 16'hA5A5;
    ack_data[1] = 16'h5A5A;
    ack_data[2] = 16'h1111;
    ack_data[3] = 16'h2222;

    // Reset state
    repeat (3) @(negedge clk);
    check("reset_addr",  addr, 20'h0);
    check("reset_cmd",   cmd, 4'h0);
    check("reset_wdata", wdata, 16'h0);
    check("reset_flags", {miso, miso_oe, hdr_valid, wr_valid, rd_req, busy, err_rd_late}, 10'h0);
    reset_n = 1'b1;
    repeat (4) @(negedge clk);

    // Quad write 0x12345 / 0xBEEF
    frame_begin(2'b11);
    check("quad_busy_in_frame", busy, 1'b1);
    send_bits(32'h412345, 24, 4);
    send_bits(32'h0000BEEF, 16, 4);
    frame_end();
    check("quad_hdr_count", hdr_cnt, 1);
    check("quad_hdr_addr",  hdr_addr, 20'h12345);
    check("quad_hdr_cmd",   hdr_cmd, 4'h4);
    check("quad_wr_count",  wr_cnt, 1);
    check("quad_wr_addr",   wr_addr, 20'h12345);
    check("quad_wr_data",   wr_data, 16'hBEEF);
    check("quad_no_rd_req", rd_cnt, 0);
    check("quad_idle_busy", busy, 1'b0);

    // Single-lane burst read from 0xFFFFF, wrapping to 0x00000
    ack_en = 1'b1;
    frame_begin(2'b01);
    send_bits(32'h2FFFFF, 24, 1);
    send_bits(32'h0, 4, 1);
    recv_bits(16, 1, word0, oe0, hz0);
    send_bits(32'h0, 4, 1);
    recv_bits(16, 1, word1, oe1, hz1);
    frame_end();
    ack_en = 1'b0;
    check("burst_hdr_cmd",    hdr_cmd, 4'h2);
    check("burst_word0",      word0, 32'hA5A5);
    check("burst_word1",      word1, 32'h5A5A);
    check("burst_rd_addr0",   rd_addr[0], 20'hFFFFF);
    check("burst_rd_addr1",   rd_addr[1], 20'h00000);
    check("burst_rd_req_ge2", rd_cnt >= 2, 1'b1);
    check("burst_oe",         oe0 & oe1, 1'b1);
    check("burst_hi_lanes0",  hz0 & hz1, 1'b1);
    check("burst_no_err",     err_rd_late, 1'b0);
    check("burst_no_wr",      wr_cnt, 1);
    check("burst_oe_after",   miso_oe, 1'b0);

    // Dual-lane read with no rd_ack
    r0 = rd_cnt;
    frame_begin(2'b10);
    send_bits(32'h000ABC, 24, 2);
    send_bits(32'h0, 8, 2);
    recv_bits(16, 2, word0, oe0, hz0);
    frame_end();
    check("late_rd_req",    rd_cnt - r0, 1);
    check("late_word_zero", word0, 32'h0);
    check("late_oe",        oe0, 1'b1);
    check("late_err_set",   err_rd_late, 1'b1);

    // Next frame start clears the flag; cs_n rises after 8 of 16 write bits
    h0 = hdr_cnt;
    w0 = wr_cnt;
    frame_begin(2'b11);
    check("late_err_cleared", err_rd_late, 1'b0);
    send_bits(32'h4ABCDE, 24, 4);
    send_bits(32'h77, 8, 4);
    @(negedge clk);
    cs_n = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("abort_busy_3clk", busy, 1'b0);
    check("abort_oe",        miso_oe, 1'b0);
    repeat (10) @(negedge clk);
    check("abort_hdr_seen",  hdr_cnt - h0, 1);
    check("abort_no_wr",     wr_cnt - w0, 0);
    check("abort_addr_held", addr, 20'hABCDE);
    check("abort_cmd_held",  cmd, 4'h4);
    check("abort_wdata_old", wdata, 16'hBEEF);

    // Disabled lane mode: full write stimulus is ignored
    h0 = hdr_cnt;
    w0 = wr_cnt;
    frame_begin(2'b00);
    send_bits(32'h455555, 24, 4);
    check("off_oe_mid", miso_oe, 1'b0);
    send_bits(32'hCAFE, 16, 4);
    frame_end();
    check("off_no_hdr", hdr_cnt - h0, 0);
    check("off_no_wr",  wr_cnt - w0, 0);
    check("off_addr",   addr, 20'hABCDE);
    check("off_wdata",  wdata, 16'hBEEF);
    check("off_busy",   busy, 1'b0);

    // Reset during a quad header, then a clean write
    h0 = hdr_cnt;
    w0 = wr_cnt;
    frame_begin(2'b11);
    send_bits(32'h345, 12, 4);
    check("rst_busy_before", busy, 1'b1);
    @(negedge clk);
    reset_n = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_mid_addr",  addr, 20'h0);
    check("rst_mid_cmd",   cmd, 4'h0);
    check("rst_mid_wdata", wdata, 16'h0);
    check("rst_mid_flags", {miso, miso_oe, hdr_valid, wr_valid, rd_req, busy, err_rd_late}, 10'h0);
    reset_n = 1'b1;
    send_bits(32'h412, 12, 4);
    send_bits(32'h9999, 16, 4);
    check("rst_no_resume_busy", busy, 1'b0);
    frame_end();
    check("rst_no_resume_hdr", hdr_cnt - h0, 0);
    check("rst_no_resume_wr",  wr_cnt - w0, 0);

    frame_begin(2'b11);
    send_bits(32'h40F00D, 24, 4);
    send_bits(32'h1234, 16, 4);
    frame_end();
    check("post_rst_hdr",     hdr_cnt - h0, 1);
    check("post_rst_hdraddr", hdr_addr, 20'h0F00D);
    check("post_rst_wr",      wr_cnt - w0, 1);
    check("post_rst_wraddr",  wr_addr, 20'h0F00D);
    check("post_rst_wdata",   wr_data, 16'h1234);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
